// File: rtl/ula_regs.sv
// ula_regs: operand capture, ALU execute and result/flag registers of the 4-bit CPU.
// Optional shift-add multiplier (opcode 7) is built only when ULA_MUL_EN is defined.
`default_nettype none

module ula_regs #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       tx,
    input  logic [WIDTH-1:0] entrada,
    input  logic             contador,
    output logic [WIDTH-1:0] reg_x,
    output logic [WIDTH-1:0] reg_y,
    output logic [WIDTH-1:0] reg_z,
    output logic             carry,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    localparam logic [3:0] CLEAR  = 4'd0;
    localparam logic [3:0] LOAD   = 4'd1;
    localparam logic [3:0] HOLD   = 4'd2;
    localparam logic [3:0] ADD    = 4'd3;
    localparam logic [3:0] SUB    = 4'd4;
    localparam logic [3:0] AND_OP = 4'd5;
    localparam logic [3:0] OR_OP  = 4'd6;
    localparam logic [3:0] MUL    = 4'd7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       tx_q, op_q, op_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic [WIDTH:0]   res_q, res_d;
    logic             carry_q, carry_d, zero_q, zero_d, done_q, done_d;
    logic             start_op;

`ifdef ULA_MUL_EN
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d, prod_n;
    assign start_op = (tx == ADD) || (tx == SUB) || (tx == AND_OP) ||
                      (tx == OR_OP) || (tx == MUL);
`else
    assign start_op = (tx == ADD) || (tx == SUB) || (tx == AND_OP) || (tx == OR_OP);
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            tx_q    <= CLEAR;
            op_q    <= HOLD;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ULA_MUL_EN
            cnt_q   <= '0;
            prod_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            tx_q    <= tx;
            op_q    <= op_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
`ifdef ULA_MUL_EN
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        res_d   = res_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        done_d  = 1'b0;
`ifdef ULA_MUL_EN
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        prod_n  = prod_q + (y_q[cnt_q] ? ({{WIDTH{1'b0}}, x_q} << cnt_q) : '0);
`endif
        if (tx == CLEAR) begin
            state_d = S_IDLE;
            x_d     = '0;
            y_d     = '0;
            z_d     = '0;
            carry_d = 1'b0;
            zero_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // MEM's registered operand lags the LOAD opcode by one edge.
                    if (tx_q == LOAD) begin
                        if (contador) x_d = entrada;
                        else          y_d = entrada;
                    end
                    if (start_op && (tx != tx_q)) begin
                        op_d    = tx;
                        state_d = S_EXEC;
`ifdef ULA_MUL_EN
                        cnt_d   = '0;
                        prod_d  = '0;
`endif
                    end
                end
                S_EXEC: begin
                    state_d = S_WRITE;
                    case (op_q)
                        ADD:     res_d = {1'b0, x_q} + {1'b0, y_q};
                        SUB:     res_d = {1'b0, x_q} - {1'b0, y_q};
                        AND_OP:  res_d = {1'b0, x_q & y_q};
                        OR_OP:   res_d = {1'b0, x_q | y_q};
`ifdef ULA_MUL_EN
                        MUL: begin
                            prod_d = prod_n;
                            res_d  = {|prod_n[2*WIDTH-1:WIDTH], prod_n[WIDTH-1:0]};
                            if (cnt_q != CW'(WIDTH - 1)) begin
                                state_d = S_EXEC;
                                cnt_d   = cnt_q + 1'b1;
                            end
                        end
`endif
                        default: res_d = res_q;
                    endcase
                end
                S_WRITE: begin
                    state_d = S_IDLE;
                    z_d     = res_q[WIDTH-1:0];
                    carry_d = res_q[WIDTH];
                    zero_d  = (res_q[WIDTH-1:0] == '0);
                    done_d  = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign reg_x = x_q;
    assign reg_y = y_q;
    assign reg_z = z_q;
    assign carry = carry_q;
    assign zero  = zero_q;
    assign done  = done_q;
    assign busy  = (state_q != S_IDLE);
    assign state = state_q;

endmodule

`default_nettype wire

// File: tb/tb_ula_regs.sv
// Directed self-checking bench for ula_regs (add ULA_MUL_EN to exercise the multiplier).
`default_nettype none

module tb_ula_regs;

    localparam logic [3:0] CLEAR = 4'd0, LOAD = 4'd1, HOLD = 4'd2, ADD = 4'd3,
                           SUB = 4'd4, AND_OP = 4'd5, OR_OP = 4'd6, MUL = 4'd7;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] tx;
    logic [3:0] entrada;
    logic       contador;
    logic [3:0] reg_x, reg_y, reg_z;
    logic       carry, zero, busy, done;
    logic [1:0] state;

    int n_vec = 0;
    int n_bad = 0;

    ula_regs #(.WIDTH(4)) dut (
        .clock(clock), .reset(reset), .tx(tx), .entrada(entrada), .contador(contador),
        .reg_x(reg_x), .reg_y(reg_y), .reg_z(reg_z), .carry(carry), .zero(zero),
        .busy(busy), .done(done), .state(state)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Mimics MEM: operand appears one edge after the LOAD opcode, in1 then in2.
    task automatic load_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        tx = LOAD;
        tick();
        entrada = a; contador = 1'b1;
        tick();
        entrada = b; contador = 1'b0; tx = op;
        tick();
    endtask

    task automatic run(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] op, input logic [3:0] ez, input logic ec,
                       input logic ezero);
        load_op(a, b, op);
        check({tag, ".x"}, reg_x, a);
        check({tag, ".y"}, reg_y, b);
        check({tag, ".exec"}, state, 1);
        tick();
        check({tag, ".done_early"}, done, 0);
        tick();
        check({tag, ".done"}, done, 1);
        check({tag, ".z"}, reg_z, ez);
        check({tag, ".carry"}, carry, ec);
        check({tag, ".zero"}, zero, ezero);
        tx = HOLD;
        tick();
        check({tag, ".done_pulse"}, done, 0);
        check({tag, ".idle"}, busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        int pulses;
        int busy_cycles;
        reset = 1'b1; tx = HOLD; entrada = '0; contador = 1'b0;
        tick(); tick();
        check("rst.state", state, 0);
        check("rst.xyz", {reg_x, reg_y, reg_z}, 0);
        check("rst.flags", {carry, zero, busy, done}, 0);
        reset = 1'b0;
        tick();

        run("add53", 4'd5, 4'd3, ADD, 4'd8, 1'b0, 1'b0);
        run("add99", 4'd9, 4'd9, ADD, 4'd2, 1'b1, 1'b0);
        run("sub35", 4'd3, 4'd5, SUB, 4'd14, 1'b1, 1'b0);
        run("sub44", 4'd4, 4'd4, SUB, 4'd0, 1'b0, 1'b1);
        run("and", 4'd12, 4'd10, AND_OP, 4'd8, 1'b0, 1'b0);
        run("or", 4'd12, 4'd3, OR_OP, 4'd15, 1'b0, 1'b0);

        // Opcode held on tx: executes exactly once.
        load_op(4'd6, 4'd1, ADD);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) pulses++;
        end
        check("held.pulses", pulses, 1);
        check("held.z", reg_z, 7);
        tx = HOLD;
        tick();

        // LOAD while busy must not disturb X/Y.
        load_op(4'd2, 4'd2, SUB);
        tx = LOAD; entrada = 4'd9; contador = 1'b1;
        tick();
        contador = 1'b0;
        tick();
        check("busyload.done", done, 1);
        check("busyload.x", reg_x, 2);
        check("busyload.y", reg_y, 2);
        check("busyload.z", {reg_z, zero}, {4'd0, 1'b1});
        tx = HOLD;
        tick();

        // CLEAR during EXEC.
        run("pre_clr", 4'd9, 4'd9, ADD, 4'd2, 1'b1, 1'b0);
        load_op(4'd7, 4'd7, ADD);
        tx = CLEAR;
        tick();
        check("clr.xyz", {reg_x, reg_y, reg_z}, 0);
        check("clr.flags", {carry, zero, busy, done}, 0);
        check("clr.state", state, 0);
        tx = HOLD;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done) pulses++;
        end
        check("clr.nodone", pulses, 0);

        // Async reset mid-EXEC.
        run("pre_rst", 4'd1, 4'd1, ADD, 4'd2, 1'b0, 1'b0);
        load_op(4'd5, 4'd3, ADD);
        #2 reset = 1'b1;
        #1;
        check("arst.state", state, 0);
        check("arst.xyz", {reg_x, reg_y, reg_z}, 0);
        check("arst.flags", {carry, zero, busy, done}, 0);
        tx = HOLD;
        tick();
        #3 reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done) pulses++;
        end
        check("arst.nodone", pulses, 0);

`ifdef ULA_MUL_EN
        load_op(4'd7, 4'd3, MUL);
        busy_cycles = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (busy) busy_cycles++;
            tick();
        end
        check("mul.done", done, 1);
        check("mul.busy", busy_cycles, 5);
        check("mul.z", reg_z, 5);
        check("mul.carry", carry, 1);
        tx = HOLD;
        tick();
`else
        tx = MUL;
        busy_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (busy) busy_cycles++;
        end
        check("op7.busy", busy_cycles, 0);
        check("op7.state", state, 0);
        check("op7.done", done, 0);
        tx = HOLD;
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
